// File: rtl/branch_resolve_unit.sv
// EX-stage branch resolution unit.
// Resolves the branch or jump in EX and checks it against the fetch-time prediction.
// Produces a registered predictor update, a front-end redirect and a multi-cycle
// flush of the wrong-path IF/ID contents. Also keeps saturating branch and
// mispredict counters.
module branch_resolve_unit #(
  parameter int XLEN         = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             ex_valid,
  input  logic             is_branch,
  input  logic             is_jal,
  input  logic             is_jalr,
  input  logic [2:0]       funct3,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic [XLEN-1:0]  rs2_val,
  input  logic [XLEN-1:0]  imm,
  input  logic             pred_taken,
  input  logic [XLEN-1:0]  pred_addr,
  output logic             upd_valid,
  output logic [XLEN-1:0]  upd_pc,
  output logic             upd_taken,
  output logic [XLEN-1:0]  upd_target,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush,
  output logic             illegal_br,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mispred_count
);

  logic [2:0]      flush_cnt;
  logic            one_hot;
  logic            accept;
  logic            cond_true;
  logic            bad_funct3;
  logic            taken;
  logic            mispred;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fall_through;

  // Decode the instruction in EX: condition outcome, target, mispredict and acceptance.
  always_comb begin
    cond_true    = 1'b0;
    bad_funct3   = 1'b0;
    one_hot      = ({is_branch, is_jal, is_jalr} == 3'b100) ||
                   ({is_branch, is_jal, is_jalr} == 3'b010) ||
                   ({is_branch, is_jal, is_jalr} == 3'b001);
    case (funct3)
      3'b000:  cond_true = (rs1_val == rs2_val);
      3'b001:  cond_true = (rs1_val != rs2_val);
      3'b100:  cond_true = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  cond_true = !($signed(rs1_val) < $signed(rs2_val));
      3'b110:  cond_true = (rs1_val < rs2_val);
      3'b111:  cond_true = !(rs1_val < rs2_val);
      default: bad_funct3 = 1'b1;
    endcase
    taken        = is_jal || is_jalr || (is_branch && cond_true);
    jalr_sum     = rs1_val + imm;
    target       = is_jalr ? {jalr_sum[XLEN-1:1], 1'b0} : (ex_pc + imm);
    fall_through = ex_pc + XLEN'(4);
    mispred      = (pred_taken != taken) || (taken && (pred_addr != target));
    accept       = ex_valid && !stall && (flush_cnt == 3'd0) && one_hot;
  end

  assign flush = (flush_cnt != 3'd0);

  // Register the predictor update and redirect, and run the flush window countdown.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_taken      <= 1'b0;
      upd_target     <= '0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      illegal_br     <= 1'b0;
      flush_cnt      <= 3'd0;
    end else begin
      upd_valid      <= accept;
      redirect_valid <= accept && mispred;
      illegal_br     <= accept && is_branch && bad_funct3;
      if (accept) begin
        upd_pc     <= ex_pc;
        upd_taken  <= taken;
        upd_target <= target;
      end
      if (accept && mispred) begin
        redirect_pc <= taken ? target : fall_through;
        flush_cnt   <= 3'(FLUSH_CYCLES);
      end else if (flush_cnt != 3'd0) begin
        flush_cnt <= flush_cnt - 3'd1;
      end
    end
  end

  // Saturating statistics counters for resolved transfers and mispredicts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      br_count      <= '0;
      mispred_count <= '0;
    end else if (accept) begin
      if (br_count != '1) begin
        br_count <= br_count + CNT_W'(1);
      end
      if (mispred && (mispred_count != '1)) begin
        mispred_count <= mispred_count + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench for branch_resolve_unit: directed cases with literal expectations plus
// randomized traffic checked every cycle against a behavioural model.
module tb_branch_resolve_unit;

  localparam int XLEN = 32;
  localparam int FC   = 2;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        ex_valid;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic [2:0]  funct3;
  logic [31:0] ex_pc;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [31:0] imm;
  logic        pred_taken;
  logic [31:0] pred_addr;

  logic        upd_valid, upd_taken, redirect_valid, flush, illegal_br;
  logic [31:0] upd_pc, upd_target, redirect_pc;
  logic [15:0] br_count, mispred_count;

  logic        s_upd_valid, s_upd_taken, s_redirect_valid, s_flush, s_illegal_br;
  logic [31:0] s_upd_pc, s_upd_target, s_redirect_pc;
  logic [3:0]  s_br_count, s_mispred_count;

  int testsRun;
  int testsFailed;

  logic        expUpdValid, expUpdTaken, expRedirValid, expFlush, expIllegal;
  logic [31:0] expUpdPc, expUpdTarget, expRedirPc;
  int          brTotal, misTotal;
  int          edgeIdx, lastMisEdge;

  branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .stall(stall), .ex_valid(ex_valid),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
    .ex_pc(ex_pc), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .pred_taken(pred_taken), .pred_addr(pred_addr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .illegal_br(illegal_br), .br_count(br_count), .mispred_count(mispred_count)
  );

  branch_resolve_unit #(.XLEN(32), .FLUSH_CYCLES(FC), .CNT_W(4)) dutSmall (
    .clk(clk), .reset(reset), .stall(stall), .ex_valid(ex_valid),
    .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr), .funct3(funct3),
    .ex_pc(ex_pc), .rs1_val(rs1_val), .rs2_val(rs2_val), .imm(imm),
    .pred_taken(pred_taken), .pred_addr(pred_addr),
    .upd_valid(s_upd_valid), .upd_pc(s_upd_pc), .upd_taken(s_upd_taken), .upd_target(s_upd_target),
    .redirect_valid(s_redirect_valid), .redirect_pc(s_redirect_pc), .flush(s_flush),
    .illegal_br(s_illegal_br), .br_count(s_br_count), .mispred_count(s_mispred_count)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic modelTaken(input logic br, input logic j, input logic jr,
                                      input logic [2:0] f3, input logic [31:0] a,
                                      input logic [31:0] b);
    int sa, sb;
    sa = int'(a);
    sb = int'(b);
    if (j || jr) return 1'b1;
    if (!br) return 1'b0;
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return sa < sb;
      3'd5:    return sa >= sb;
      3'd6:    return a < b;
      3'd7:    return a >= b;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] modelTarget(input logic jr, input logic [31:0] pc,
                                              input logic [31:0] a, input logic [31:0] im);
    logic [31:0] t;
    if (jr) begin
      t = a + im;
      return t & 32'hFFFF_FFFE;
    end
    return pc + im;
  endfunction

  // Behavioural model: decides per clock edge what the DUT must show after that edge.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      expUpdValid   = 1'b0;
      expUpdTaken   = 1'b0;
      expRedirValid = 1'b0;
      expFlush      = 1'b0;
      expIllegal    = 1'b0;
      expUpdPc      = '0;
      expUpdTarget  = '0;
      expRedirPc    = '0;
      brTotal       = 0;
      misTotal      = 0;
      edgeIdx       = 0;
      lastMisEdge   = -100;
    end else begin
      int kinds;
      logic acc, tk, mis;
      logic [31:0] tg;
      edgeIdx = edgeIdx + 1;
      kinds = int'(is_branch) + int'(is_jal) + int'(is_jalr);
      acc = ex_valid && !stall && kinds == 1 &&
            !((edgeIdx - lastMisEdge) >= 1 && (edgeIdx - lastMisEdge) <= FC);
      expUpdValid   = acc;
      expRedirValid = 1'b0;
      expIllegal    = 1'b0;
      if (acc) begin
        tk  = modelTaken(is_branch, is_jal, is_jalr, funct3, rs1_val, rs2_val);
        tg  = modelTarget(is_jalr, ex_pc, rs1_val, imm);
        mis = (pred_taken != tk) || (tk && pred_addr != tg);
        expUpdPc     = ex_pc;
        expUpdTaken  = tk;
        expUpdTarget = tg;
        expIllegal   = is_branch && (funct3 == 3'd2 || funct3 == 3'd3);
        brTotal      = brTotal + 1;
        if (mis) begin
          expRedirValid = 1'b1;
          expRedirPc    = tk ? tg : ex_pc + 32'd4;
          misTotal      = misTotal + 1;
          lastMisEdge   = edgeIdx;
        end
      end
      expFlush = (edgeIdx - lastMisEdge) >= 0 && (edgeIdx - lastMisEdge) < FC;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun = testsRun + 1;
    if (actual !== expected) begin
      testsFailed = testsFailed + 1;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Compare process: every falling edge out of reset, DUT outputs versus the model.
  always @(negedge clk) begin
    if (reset) begin
      checkOutput("cmp upd_valid", 32'(upd_valid), 32'(expUpdValid));
      if (expUpdValid) begin
        checkOutput("cmp upd_pc", upd_pc, expUpdPc);
        checkOutput("cmp upd_taken", 32'(upd_taken), 32'(expUpdTaken));
        checkOutput("cmp upd_target", upd_target, expUpdTarget);
      end
      checkOutput("cmp redirect_valid", 32'(redirect_valid), 32'(expRedirValid));
      if (expRedirValid) checkOutput("cmp redirect_pc", redirect_pc, expRedirPc);
      checkOutput("cmp flush", 32'(flush), 32'(expFlush));
      checkOutput("cmp illegal_br", 32'(illegal_br), 32'(expIllegal));
      checkOutput("cmp br_count", 32'(br_count), 32'(brTotal > 65535 ? 65535 : brTotal));
      checkOutput("cmp mispred_count", 32'(mispred_count),
                  32'(misTotal > 65535 ? 65535 : misTotal));
      checkOutput("cmp small br_count", 32'(s_br_count), 32'(brTotal > 15 ? 15 : brTotal));
      checkOutput("cmp small mispred_count", 32'(s_mispred_count),
                  32'(misTotal > 15 ? 15 : misTotal));
    end
  end

  task automatic applyStimulus(input logic v, input logic br, input logic j, input logic jr,
                               input logic [2:0] f3, input logic [31:0] pc,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] im, input logic pt,
                               input logic [31:0] pa, input logic st);
    ex_valid   = v;
    is_branch  = br;
    is_jal     = j;
    is_jalr    = jr;
    funct3     = f3;
    ex_pc      = pc;
    rs1_val    = a;
    rs2_val    = b;
    imm        = im;
    pred_taken = pt;
    pred_addr  = pa;
    stall      = st;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [31:0] r, pa, tg;
    logic tk;
    testsRun    = 0;
    testsFailed = 0;
    reset = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #2;
    checkOutput("reset upd_valid", 32'(upd_valid), 32'd0);
    checkOutput("reset redirect_valid", 32'(redirect_valid), 32'd0);
    checkOutput("reset flush", 32'(flush), 32'd0);
    checkOutput("reset br_count", 32'(br_count), 32'd0);
    checkOutput("reset upd_pc", upd_pc, 32'd0);
    reset = 1'b1;
    step();

    applyStimulus(1, 1, 0, 0, 3'd0, 32'h100, 32'd5, 32'd5, 32'h20, 1, 32'h120, 0);
    step();
    idle();
    checkOutput("beq upd_valid", 32'(upd_valid), 32'd1);
    checkOutput("beq upd_pc", upd_pc, 32'h100);
    checkOutput("beq upd_taken", 32'(upd_taken), 32'd1);
    checkOutput("beq upd_target", upd_target, 32'h120);
    checkOutput("beq redirect_valid", 32'(redirect_valid), 32'd0);
    checkOutput("beq flush", 32'(flush), 32'd0);
    checkOutput("beq br_count", 32'(br_count), 32'd1);
    checkOutput("beq mispred_count", 32'(mispred_count), 32'd0);

    applyStimulus(1, 1, 0, 0, 3'd4, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 0, 32'h0, 0);
    step();
    applyStimulus(1, 1, 0, 0, 3'd0, 32'h400, 32'd7, 32'd7, 32'h8, 1, 32'h408, 0);
    checkOutput("blt redirect_valid", 32'(redirect_valid), 32'd1);
    checkOutput("blt redirect_pc", redirect_pc, 32'h240);
    checkOutput("blt flush first", 32'(flush), 32'd1);
    checkOutput("blt mispred_count", 32'(mispred_count), 32'd1);
    step();
    checkOutput("flush second cycle", 32'(flush), 32'd1);
    checkOutput("squash upd_valid 1", 32'(upd_valid), 32'd0);
    checkOutput("redirect one cycle", 32'(redirect_valid), 32'd0);
    step();
    checkOutput("flush ended", 32'(flush), 32'd0);
    checkOutput("squash upd_valid 2", 32'(upd_valid), 32'd0);
    checkOutput("squash br_count", 32'(br_count), 32'd2);
    step();
    idle();
    checkOutput("post flush accept", 32'(upd_valid), 32'd1);
    checkOutput("post flush br_count", 32'(br_count), 32'd3);

    applyStimulus(1, 1, 0, 0, 3'd6, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 1, 32'h240, 0);
    step();
    idle();
    checkOutput("bltu redirect_pc", redirect_pc, 32'h204);
    checkOutput("bltu upd_taken", 32'(upd_taken), 32'd0);
    checkOutput("bltu upd_target", upd_target, 32'h240);
    step();
    step();

    applyStimulus(1, 0, 0, 1, 3'd0, 32'h600, 32'h1003, 32'd0, 32'h4, 1, 32'h1006, 0);
    step();
    idle();
    checkOutput("jalr ok redirect_valid", 32'(redirect_valid), 32'd0);
    checkOutput("jalr ok upd_target", upd_target, 32'h1006);
    applyStimulus(1, 0, 0, 1, 3'd0, 32'h600, 32'h1003, 32'd0, 32'h4, 1, 32'h2000, 0);
    step();
    idle();
    checkOutput("jalr bad redirect_valid", 32'(redirect_valid), 32'd1);
    checkOutput("jalr bad redirect_pc", redirect_pc, 32'h1006);
    step();
    step();

    applyStimulus(1, 1, 0, 0, 3'd1, 32'h300, 32'd1, 32'd2, 32'h10, 1, 32'h310, 1);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("stall upd_valid", 32'(upd_valid), 32'd0);
      checkOutput("stall br_count", 32'(br_count), 32'd6);
    end
    stall = 1'b0;
    step();
    idle();
    checkOutput("release upd_valid", 32'(upd_valid), 32'd1);
    checkOutput("release br_count", 32'(br_count), 32'd7);
    step();
    checkOutput("release single update", 32'(upd_valid), 32'd0);

    applyStimulus(1, 1, 0, 0, 3'd2, 32'h500, 32'd3, 32'd3, 32'h10, 0, 32'h0, 0);
    step();
    idle();
    checkOutput("illegal pulse", 32'(illegal_br), 32'd1);
    checkOutput("illegal upd_taken", 32'(upd_taken), 32'd0);
    checkOutput("illegal upd_valid", 32'(upd_valid), 32'd1);
    checkOutput("illegal upd_target", upd_target, 32'h510);
    step();
    checkOutput("illegal one cycle", 32'(illegal_br), 32'd0);

    applyStimulus(1, 0, 1, 0, 3'd0, 32'h700, 32'd0, 32'd0, 32'h80, 0, 32'h0, 0);
    step();
    idle();
    checkOutput("pre-reset flush", 32'(flush), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("async reset flush", 32'(flush), 32'd0);
    checkOutput("async reset redirect", 32'(redirect_valid), 32'd0);
    checkOutput("async reset br_count", 32'(br_count), 32'd0);
    checkOutput("async reset mispred_count", 32'(mispred_count), 32'd0);
    step();
    reset = 1'b1;
    step();

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 1, 0, 3'd0, 32'h1000 + 32'(i * 4), 32'd0, 32'd0, 32'h8, 0, 32'h0, 0);
      step();
      idle();
      step();
      step();
    end
    checkOutput("sat small br_count", 32'(s_br_count), 32'd15);
    checkOutput("sat small mispred_count", 32'(s_mispred_count), 32'd15);
    checkOutput("wide mispred_count", 32'(mispred_count), 32'd20);

    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      applyStimulus($urandom_range(0, 3) != 0, 1'b0, 1'b0, 1'b0, 3'($urandom),
                    $urandom & 32'hFFFF_FFFC,
                    $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 8)),
                    32'($urandom_range(0, 8)), {{20{r[11]}}, r[11:0]},
                    1'($urandom), 32'd0, $urandom_range(0, 4) == 0);
      case ($urandom_range(0, 9))
        4:       is_jal = 1'b1;
        5:       is_jalr = 1'b1;
        6:       begin is_branch = 1'b1; is_jal = 1'b1; end
        7:       ;
        default: is_branch = 1'b1;
      endcase
      if ($urandom_range(0, 2) == 0) rs2_val = rs1_val;
      tk = modelTaken(is_branch, is_jal, is_jalr, funct3, rs1_val, rs2_val);
      tg = modelTarget(is_jalr, ex_pc, rs1_val, imm);
      pa = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        pred_taken = tk;
        pa = tg;
      end
      pred_addr = pa;
      step();
    end
    idle();
    step();

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
